// File: rtl/temporizador_turno_param.sv
`default_nettype none
// ============================================================================
// Module  : temporizador_turno_param
// Brief   : Per-turn countdown timer with pause and low-time alert. On timeout
//           it searches for a free column and emits a one-hot auto-move pulse.
// Rev     : 1.0
// ============================================================================
module temporizador_turno_param #(
    parameter int          CICLOS_POR_SEG = 25_175_000,
    parameter int          SEGUNDOS_MAX   = 10,
    parameter int          UMBRAL_ALERTA  = 3,
    parameter int          N_FILAS        = 6,
    parameter int          N_COLS         = 7,
    parameter logic [15:0] SEMILLA        = 16'hACE1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 movimiento_hecho,
    input  logic                                 pausa,
    input  logic [N_FILAS-1:0][N_COLS-1:0][1:0]  tablero,
    output logic [N_COLS-1:0]                    pulsos_random,
    output logic [7:0]                           contador,
    output logic                                 tick_seg,
    output logic                                 alerta,
    output logic                                 sin_columna
);

    localparam int              c_SW        = (CICLOS_POR_SEG > 1) ? $clog2(CICLOS_POR_SEG) : 1;
    localparam int              c_CW        = $clog2(N_COLS);
    localparam logic [c_SW-1:0] c_SEG_LAST  = c_SW'(CICLOS_POR_SEG - 1);
    localparam logic [7:0]      c_SEG_MAX   = 8'(SEGUNDOS_MAX);
    localparam logic [7:0]      c_UMBRAL    = 8'(UMBRAL_ALERTA);
    localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(N_COLS - 1);
    localparam logic [15:0]     c_NCOLS16   = 16'(N_COLS);
    localparam logic [N_COLS-1:0] c_ONE     = {{(N_COLS-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_COUNT  = 2'd1;
    localparam logic [1:0] c_S_SEARCH = 2'd2;
    localparam logic [1:0] c_S_PULSE  = 2'd3;

    logic [1:0]        r_state;
    logic [c_SW-1:0]   r_seg_cnt;
    logic [7:0]        r_restantes;
    logic [15:0]       r_lfsr;
    logic              r_enable_q;
    logic [c_CW-1:0]   r_cand;
    logic [c_CW-1:0]   r_intentos;
    logic [N_COLS-1:0] r_pulsos;
    logic              r_tick;
    logic              r_sin_col;

    logic [15:0]       w_lfsr_next;
    logic [c_CW-1:0]   w_start;
    logic              w_top_empty;
    logic              w_unused_filas;

    // Fibonacci LFSR, taps 16,14,13,11; an all-zero value is forced back to 1
    assign w_lfsr_next = (r_lfsr == 16'h0000) ? 16'h0001
                       : {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_start     = c_CW'(r_lfsr % c_NCOLS16);
    assign w_top_empty = (tablero[0][r_cand] == 2'b00);

    // Only the top row decides whether a column accepts a piece
    assign w_unused_filas = ^tablero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_S_IDLE;
            r_seg_cnt   <= '0;
            r_restantes <= c_SEG_MAX;
            r_lfsr      <= SEMILLA;
            r_enable_q  <= 1'b0;
            r_cand      <= '0;
            r_intentos  <= '0;
            r_pulsos    <= '0;
            r_tick      <= 1'b0;
            r_sin_col   <= 1'b0;
        end else begin
            r_lfsr     <= w_lfsr_next;
            r_enable_q <= enable;
            r_pulsos   <= '0;
            r_tick     <= 1'b0;
            r_sin_col  <= 1'b0;
            if (!enable) begin
                r_state     <= c_S_IDLE;
                r_seg_cnt   <= '0;
                r_restantes <= c_SEG_MAX;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (!r_enable_q) begin
                            r_state     <= c_S_COUNT;
                            r_seg_cnt   <= '0;
                            r_restantes <= c_SEG_MAX;
                        end
                    end
                    c_S_COUNT: begin
                        if (movimiento_hecho) begin
                            r_seg_cnt   <= '0;
                            r_restantes <= c_SEG_MAX;
                        end else if (!pausa) begin
                            if (r_seg_cnt == c_SEG_LAST) begin
                                r_seg_cnt   <= '0;
                                r_restantes <= r_restantes - 8'd1;
                                r_tick      <= 1'b1;
                                if (r_restantes == 8'd1) begin
                                    r_state    <= c_S_SEARCH;
                                    r_cand     <= w_start;
                                    r_intentos <= '0;
                                end
                            end else begin
                                r_seg_cnt <= r_seg_cnt + 1'b1;
                            end
                        end
                    end
                    c_S_SEARCH: begin
                        if (movimiento_hecho) begin
                            r_state     <= c_S_COUNT;
                            r_seg_cnt   <= '0;
                            r_restantes <= c_SEG_MAX;
                        end else if (w_top_empty) begin
                            r_state  <= c_S_PULSE;
                            r_pulsos <= c_ONE << r_cand;
                        end else if (r_intentos == c_COL_LAST) begin
                            // Board full: give up this turn and wait for a fresh enable edge
                            r_state     <= c_S_IDLE;
                            r_sin_col   <= 1'b1;
                            r_seg_cnt   <= '0;
                            r_restantes <= c_SEG_MAX;
                        end else begin
                            r_cand     <= (r_cand == c_COL_LAST) ? '0 : r_cand + 1'b1;
                            r_intentos <= r_intentos + 1'b1;
                        end
                    end
                    c_S_PULSE: begin
                        r_state     <= c_S_COUNT;
                        r_seg_cnt   <= '0;
                        r_restantes <= c_SEG_MAX;
                    end
                    default: begin
                        r_state <= c_S_IDLE;
                    end
                endcase
            end
        end
    end

    assign pulsos_random = r_pulsos;
    assign contador      = r_restantes;
    assign tick_seg      = r_tick;
    assign sin_columna   = r_sin_col;
    assign alerta        = (r_state == c_S_COUNT) && (r_restantes != 8'd0)
                        && (r_restantes <= c_UMBRAL);

endmodule
`default_nettype wire

// File: tb/tb_temporizador_turno_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_temporizador_turno_param
// Brief   : Directed/randomised bench for the turn timer against a cycle-level
//           reference built from elapsed-cycle arithmetic and a column scan.
// Rev     : 1.0
// ============================================================================
module tb_temporizador_turno_param;

    localparam int          CPS  = 4;
    localparam int          SMAX = 3;
    localparam int          UMB  = 1;
    localparam int          NF   = 6;
    localparam int          NC   = 7;
    localparam logic [15:0] SEED = 16'hACE1;

    logic                         clk    = 1'b0;
    logic                         reset  = 1'b1;
    logic                         enable = 1'b0;
    logic                         mov    = 1'b0;
    logic                         pausa  = 1'b0;
    logic [NF-1:0][NC-1:0][1:0]   tab;
    logic [NC-1:0]                pulsos;
    logic [7:0]                   contador;
    logic                         tick_seg;
    logic                         alerta;
    logic                         sin_col;

    int          n_err = 0;
    int          n_chk = 0;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    int          g_start;

    temporizador_turno_param #(
        .CICLOS_POR_SEG (CPS),
        .SEGUNDOS_MAX   (SMAX),
        .UMBRAL_ALERTA  (UMB),
        .N_FILAS        (NF),
        .N_COLS         (NC),
        .SEMILLA        (SEED)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .movimiento_hecho (mov),
        .pausa            (pausa),
        .tablero          (tab),
        .pulsos_random    (pulsos),
        .contador         (contador),
        .tick_seg         (tick_seg),
        .alerta           (alerta),
        .sin_columna      (sin_col)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v == 16'h0000) return 16'h0001;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; m_prev is the LFSR value the DUT saw at that edge
    task automatic step();
        @(posedge clk);
        m_prev = m_lfsr;
        if (reset) m_lfsr = lfsr_step(m_lfsr);
        #1;
    endtask

    function automatic logic exp_alert(input int rest);
        return (rest != 0) && (rest <= UMB);
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_tick"}, 32'(tick_seg), 0);
        chk({tag, "_pulse"}, 32'(pulsos), 0);
        chk({tag, "_alert"}, 32'(alerta), 0);
        chk({tag, "_sin"}, 32'(sin_col), 0);
    endtask

    // Starts with the timer freshly armed; ends on the edge entering the search
    task automatic count_phase(input int p_at, input int p_len, input int mv_at);
        int el;
        int paused;
        int mv_done;
        int ec;
        el = 0; paused = 0; mv_done = 0;
        while (el < CPS * SMAX) begin
            if (mv_at >= 0 && el == mv_at && mv_done == 0) begin
                mov = 1'b1; pausa = 1'b0;
                step();
                mov = 1'b0; mv_done = 1; el = 0;
                chk("mov_reload_cnt", 32'(contador), SMAX);
                chk("mov_no_tick", 32'(tick_seg), 0);
                chk("mov_alert", 32'(alerta), 32'(exp_alert(SMAX)));
                chk("mov_no_pulse", 32'(pulsos), 0);
            end else if (el == p_at && paused < p_len) begin
                pausa = 1'b1;
                step();
                paused++;
                ec = SMAX - el / CPS;
                chk("pause_cnt", 32'(contador), ec);
                chk("pause_tick", 32'(tick_seg), 0);
                chk("pause_alert", 32'(alerta), 32'(exp_alert(ec)));
            end else begin
                pausa = 1'b0;
                step();
                el++;
                ec = SMAX - el / CPS;
                chk("cnt", 32'(contador), ec);
                chk("tick", 32'(tick_seg), 32'(el % CPS == 0));
                chk("alert", 32'(alerta), 32'(exp_alert(ec)));
                chk("count_no_pulse", 32'(pulsos), 0);
            end
        end
        pausa   = 1'b0;
        g_start = int'(m_prev) % NC;
    endtask

    // Scans the top row from the sampled start column and checks the outcome
    task automatic search_phase();
        int off;
        int col;
        int c;
        int n_blank;
        logic [NC-1:0] ep;
        off = NC; col = -1;
        for (int i = 0; i < NC; i++) begin
            c = (g_start + i) % NC;
            if (col < 0 && tab[0][c] == 2'b00) begin
                col = c; off = i;
            end
        end
        n_blank = (col >= 0) ? off : NC - 1;
        for (int j = 0; j < n_blank; j++) begin
            step();
            chk("search_pulse", 32'(pulsos), 0);
            chk("search_cnt", 32'(contador), 0);
            chk("search_sin", 32'(sin_col), 0);
            chk("search_alert", 32'(alerta), 0);
        end
        step();
        if (col >= 0) begin
            ep = '0;
            ep[col] = 1'b1;
            chk("pulse_col", 32'(pulsos), 32'(ep));
            chk("pulse_cnt", 32'(contador), 0);
            chk("pulse_sin", 32'(sin_col), 0);
            step();
            chk("post_pulse_zero", 32'(pulsos), 0);
            chk("post_pulse_cnt", 32'(contador), SMAX);
        end else begin
            chk("sin_col", 32'(sin_col), 1);
            chk("sin_no_pulse", 32'(pulsos), 0);
            step();
            chk("sin_once", 32'(sin_col), 0);
            chk("sin_after_pulse", 32'(pulsos), 0);
        end
    endtask

    task automatic random_board();
        int z;
        for (int c = 0; c < NC; c++) begin
            for (int r = 0; r < NF; r++) tab[r][c] = 2'($urandom_range(0, 3));
        end
        z = $urandom_range(0, NC - 1);
        tab[0][z] = 2'b00;
    endtask

    initial begin
        tab    = '0;
        m_lfsr = SEED;
        m_prev = SEED;

        // Asynchronous reset before any clock edge
        #3 reset = 1'b0;
        #1;
        chk("rst_cnt", 32'(contador), SMAX);
        idle_checks("rst");
        step();
        step();
        chk("rst_hold_cnt", 32'(contador), SMAX);
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("idle_cnt", 32'(contador), SMAX);
            idle_checks("idle");
        end

        // Empty board, enable edge arms the timer
        enable = 1'b1;
        step();
        chk("arm_cnt", 32'(contador), SMAX);
        chk("arm_tick", 32'(tick_seg), 0);
        count_phase(-1, 0, -1);
        search_phase();

        // Random boards with random pauses
        for (int r = 0; r < 6; r++) begin
            random_board();
            count_phase($urandom_range(0, CPS * SMAX - 1), $urandom_range(0, 6), -1);
            search_phase();
        end

        // Only column 5 free at the top
        tab = '0;
        for (int c = 0; c < NC; c++) tab[0][c] = (c == 5) ? 2'b00 : 2'($urandom_range(1, 3));
        count_phase(-1, 0, -1);
        search_phase();

        // Move while one second remains
        tab = '0;
        count_phase(-1, 0, 9);
        search_phase();

        // Pause of 10 cycles mid-second
        count_phase(5, 10, -1);
        search_phase();

        // Move during the search aborts the auto-move
        count_phase(-1, 0, -1);
        mov = 1'b1;
        step();
        mov = 1'b0;
        chk("abort_cnt", 32'(contador), SMAX);
        chk("abort_pulse", 32'(pulsos), 0);
        chk("abort_tick", 32'(tick_seg), 0);
        count_phase(-1, 0, -1);
        search_phase();

        // Dropping enable returns to idle without counting
        enable = 1'b0;
        step();
        chk("dis_cnt", 32'(contador), SMAX);
        idle_checks("dis");
        repeat (5) begin
            step();
            chk("dis_hold_cnt", 32'(contador), SMAX);
            chk("dis_hold_tick", 32'(tick_seg), 0);
        end

        // Full top row
        for (int c = 0; c < NC; c++) tab[0][c] = 2'($urandom_range(1, 3));
        enable = 1'b1;
        step();
        chk("arm2_cnt", 32'(contador), SMAX);
        count_phase(-1, 0, -1);
        search_phase();
        repeat (2 * CPS) begin
            step();
            idle_checks("full_hold");
        end
        enable = 1'b0;
        step();
        chk("full_dis_cnt", 32'(contador), SMAX);
        enable = 1'b1;
        tab = '0;
        step();
        chk("rearm_cnt", 32'(contador), SMAX);
        chk("rearm_tick", 32'(tick_seg), 0);
        count_phase(-1, 0, -1);
        search_phase();

        // Reset asserted mid-search, observed without a clock edge
        random_board();
        count_phase(-1, 0, -1);
        #2 reset = 1'b0;
        m_lfsr = SEED;
        #1;
        chk("arst_cnt", 32'(contador), SMAX);
        idle_checks("arst");
        enable = 1'b0;
        step();
        step();
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_cnt", 32'(contador), SMAX);
            idle_checks("post_rst");
        end
        enable = 1'b1;
        step();
        chk("arm3_cnt", 32'(contador), SMAX);
        count_phase(-1, 0, -1);
        search_phase();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/temporizador_turno_param.md
Name: temporizador_turno_param

Overview:
- Parametrised successor of the turn timer for the Connect-4 game FSM.
- Counts down a configurable per-turn budget in whole seconds, with pause and low-time alert.
- On timeout, searches the board sequentially from a pseudo-random start column for a non-full column, then emits a one-cycle one-hot pulse on that column.
- Reports "no valid column" when the board is full. Sits between the game FSM (enable, movimiento_hecho, pausa) and the column-insert logic.

Parameters:
- CICLOS_POR_SEG, 25_175_000, clock cycles per second tick (≥2).
- SEGUNDOS_MAX, 10, turn budget in seconds (1..255).
- UMBRAL_ALERTA, 3, alerta asserted while 0 < remaining ≤ this value.
- N_FILAS, 6, board rows; row 0 is the top row.
- N_COLS, 7, board columns (2..16).
- SEMILLA, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  turn active; the timer arms on the rising edge.
- movimiento_hecho  in  1  player inserted a piece; reloads the timer.
- pausa  in  1  freezes countdown while high.
- tablero  in  [N_FILAS-1:0][N_COLS-1:0] x 2  board; 2'b00 = empty cell.
- pulsos_random  out  N_COLS  one-hot auto-move pulse, one cycle.
- contador  out  8  seconds remaining, zero-extended.
- tick_seg  out  1  one-cycle pulse on each decrement.
- alerta  out  1  low-time warning.
- sin_columna  out  1  one-cycle pulse when no column is valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - seg_cnt=0, restantes=SEGUNDOS_MAX, so contador=SEGUNDOS_MAX.
  - All other outputs 0.
  - lfsr=SEMILLA; enable_q=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in every state.
  - If it ever reads 0, it loads 16'h0001 instead.
- Priority each cycle: enable=0 > movimiento_hecho > pausa > normal operation.
- enable=0 in any state: next cycle IDLE, counters reloaded, outputs 0.
- IDLE:
  - enable_q registers enable.
  - On enable=1 && enable_q=0, go to COUNT with seg_cnt=0, restantes=SEGUNDOS_MAX.
  - A level-high enable without a fresh edge does not re-arm.
- COUNT:
  - movimiento_hecho=1: seg_cnt=0, restantes=SEGUNDOS_MAX, stay in COUNT, no tick.
  - pausa=1: seg_cnt and restantes hold; no tick_seg.
  - Otherwise seg_cnt increments. When seg_cnt==CICLOS_POR_SEG-1: seg_cnt wraps to 0, restantes decrements, tick_seg=1 that cycle.
  - If restantes was 1 at that tick, go to SEARCH (restantes becomes 0).
  - Timeout is therefore exactly SEGUNDOS_MAX*CICLOS_POR_SEG unpaused cycles after entering COUNT.
- SEARCH:
  - On entry: cand = lfsr % N_COLS (sampled on the transition cycle), intentos=0.
  - Each cycle, test tablero[0][cand]:
    - Empty: go to PULSE with col_sel=cand.
    - Else, if intentos==N_COLS-1: go to IDLE, sin_columna=1 for one cycle, pulsos_random stays 0.
    - Else: cand=(cand+1) wraps at N_COLS, intentos++.
  - SEARCH lasts 1..N_COLS cycles.
  - movimiento_hecho during SEARCH aborts: COUNT reloaded, no pulse.
- PULSE:
  - pulsos_random = 1<<col_sel for exactly one cycle.
  - Then COUNT with seg_cnt=0, restantes=SEGUNDOS_MAX.
- After sin_columna, the block stays IDLE until enable falls and rises again.
- Outputs:
  - alerta = (state==COUNT) && restantes!=0 && restantes≤UMBRAL_ALERTA.
  - contador = restantes in all states. It reads 0 during SEARCH and PULSE.
- tablero is sampled live during SEARCH; no internal copy.
- All outputs are registered or pure state decodes; pulsos_random is never multi-hot.

Test Plan:
(Parameters for all scenarios: CICLOS_POR_SEG=4, SEGUNDOS_MAX=3, UMBRAL_ALERTA=1, N_COLS=7, N_FILAS=6.)
- Empty board, enable rises at cycle 0, held:
  - contador 3→2→1→0, with tick_seg every 4 cycles.
  - alerta high only while contador=1.
  - SEARCH lasts 1 cycle, then exactly one pulsos_random bit = (model lfsr % 7), one cycle.
  - contador then reads 3.
- Columns 0-4 and 6 full at row 0, column 5 empty: timeout → pulsos_random=7'b0100000 within ≤7 SEARCH cycles, whatever the start column.
- Full top row: timeout → sin_columna one-cycle pulse, pulsos_random=0, IDLE. Holding enable high gives no re-arm; toggling enable 0→1 restarts the count at 3.
- movimiento_hecho asserted while contador=1: contador=3 next cycle, seg_cnt restarts, no pulse; the next timeout occurs 12 cycles later.
- pausa held 10 cycles mid-second: contador and tick_seg frozen; the timeout pulse arrives exactly 10 cycles later than the unpaused run.
- reset driven low during SEARCH: all outputs 0 immediately without a clock edge, contador=3. After release, no activity until an enable rising edge.
